imm_field_encoder: RTL and testbench

IMM_FIELD_ENCODER -- requirements
Module: imm_field_encoder

---
 rtl/imm_field_encoder_pkg.sv | 46 ++++
 rtl/imm_pack.sv | 66 ++++++
 rtl/imm_field_encoder.sv | 105 ++++++++++
 tb/tb_imm_field_encoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/imm_field_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imm_field_encoder_pkg
//  Purpose  : Shared processor definitions for immediate handling. Holds the
//             instruction-format encodings, the bit placement of each format's
//             immediate field, and a sign-run helper. The sign extender uses
//             the same definitions, so encoder and extender cannot drift.
//  Revision : 1.0 - initial release
// ============================================================================
package imm_field_encoder_pkg;

    localparam int unsigned BUS_W = 64;
    localparam int unsigned IMM_W = 26;

    // Format select carried on the Ctrl port.
    typedef enum logic [1:0] {
        FMT_I   = 2'b00,
        FMT_D   = 2'b01,
        FMT_B   = 2'b10,
        FMT_CBZ = 2'b11
    } fmt_e;

    // Field placement inside the 26-bit immediate: LSB position and width.
    localparam int unsigned I_LSB   = 10;
    localparam int unsigned I_W     = 12;
    localparam int unsigned D_LSB   = 12;
    localparam int unsigned D_W     = 9;
    localparam int unsigned B_LSB   = 0;
    localparam int unsigned B_W     = 26;
    localparam int unsigned CBZ_LSB = 5;
    localparam int unsigned CBZ_W   = 19;

    // Branch offsets are word aligned; the two low bits are implied zero.
    localparam int unsigned ALIGN_BITS = 2;

    // True when v[63:lsb] are all equal, i.e. v is the sign extension of its
    // value at bit position lsb.
    function automatic logic all_same(input logic [BUS_W-1:0] v,
                                      input int unsigned      lsb);
        logic [BUS_W-1:0] m;
        m = {BUS_W{1'b1}} << lsb;
        return ((v & m) == m) || ((v & m) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
//  Module   : imm_pack
//  Purpose  : Pure combinational fit test and field packing of a 64-bit
//             immediate into the 26-bit instruction immediate for the format
//             selected by i_ctrl. Bits outside the format's field are zero,
//             and the whole field is zero when the value does not fit.
//  Ports    : i_bus_imm [63:0] value to encode
//             i_ctrl    [1:0]  format select (I/D/B/CBZ)
//             o_imm     [25:0] packed immediate
//             o_fit            value exactly representable in the format
//  Revision : 1.0 - initial release
// ============================================================================
module imm_pack
    import imm_field_encoder_pkg::*;
(
    input  logic [BUS_W-1:0] i_bus_imm,
    input  logic [1:0]       i_ctrl,
    output logic [IMM_W-1:0] o_imm,
    output logic             o_fit
);

    logic [IMM_W-1:0] w_imm;
    logic             w_fit;
    logic             w_aligned;

    assign w_aligned = (i_bus_imm[ALIGN_BITS-1:0] == '0);

    always_comb begin
        w_imm = '0;
        w_fit = 1'b0;
        case (fmt_e'(i_ctrl))
            FMT_I: begin
                // Unsigned field: everything above the field must be zero.
                w_fit = ((i_bus_imm >> I_W) == '0);
                w_imm[I_LSB +: I_W] = i_bus_imm[I_W-1:0];
            end
            FMT_D: begin
                // Signed field: the top field bit is the sign.
                w_fit = all_same(i_bus_imm, D_W - 1);
                w_imm[D_LSB +: D_W] = i_bus_imm[D_W-1:0];
            end
            FMT_B: begin
                // Word offset: sign bit sits at field MSB + alignment shift.
                w_fit = w_aligned && all_same(i_bus_imm, B_W + ALIGN_BITS - 1);
                w_imm[B_LSB +: B_W] = i_bus_imm[ALIGN_BITS +: B_W];
            end
            FMT_CBZ: begin
                w_fit = w_aligned && all_same(i_bus_imm, CBZ_W + ALIGN_BITS - 1);
                w_imm[CBZ_LSB +: CBZ_W] = i_bus_imm[ALIGN_BITS +: CBZ_W];
            end
            default: begin
                w_fit = 1'b0;
            end
        endcase
        // A non-fitting value produces an all-zero field.
        if (!w_fit) begin
            w_imm = '0;
        end
    end

    assign o_imm = w_imm;
    assign o_fit = w_fit;

endmodule
`default_nettype wire

// File: rtl/imm_field_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : imm_field_encoder
//  Purpose  : Two-stage valid/ready pipeline that encodes a 64-bit immediate
//             into the 26-bit instruction immediate field of the selected
//             format and flags whether it is exactly representable. Counts
//             (saturating) the results delivered without a fit.
//  Ports    : Clk, Reset (sync, active high)
//             InValid/InReady   request handshake; BusImm[63:0], Ctrl[1:0]
//             OutValid/OutReady result handshake;  Imm[25:0], Fit
//             ErrCount[7:0]     saturating count of delivered Fit=0 results
//  Revision : 1.0 - initial release
// ============================================================================
module imm_field_encoder
    import imm_field_encoder_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [BUS_W-1:0] BusImm,
    input  logic [1:0]       Ctrl,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [IMM_W-1:0] Imm,
    output logic             Fit,
    output logic [7:0]       ErrCount
);

    localparam logic [7:0] C_ERR_MAX = 8'hFF;

    // Stage 1: captured request.
    logic             r_s1_valid;
    logic [BUS_W-1:0] r_s1_bus;
    logic [1:0]       r_s1_ctrl;

    // Stage 2: registered result.
    logic             r_s2_valid;
    logic [IMM_W-1:0] r_s2_imm;
    logic             r_s2_fit;

    logic [7:0]       r_err_count;

    logic             w_s2_advance;
    logic             w_accept;
    logic             w_deliver;
    logic [IMM_W-1:0] w_pack_imm;
    logic             w_pack_fit;

    // Stage 2 can take new data when it is empty or being drained this cycle,
    // which lets stage 1 refill in the same cycle (no bubbles).
    assign w_s2_advance = !r_s2_valid || OutReady;
    assign InReady      = !Reset && (!r_s1_valid || w_s2_advance);
    assign w_accept     = InValid && InReady;
    assign w_deliver    = r_s2_valid && OutReady;

    imm_pack u_imm_pack (
        .i_bus_imm (r_s1_bus),
        .i_ctrl    (r_s1_ctrl),
        .o_imm     (w_pack_imm),
        .o_fit     (w_pack_fit)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
            r_s1_bus   <= '0;
            r_s1_ctrl  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_bus   <= BusImm;
            r_s1_ctrl  <= Ctrl;
        end else if (w_s2_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s2_valid <= 1'b0;
            r_s2_imm   <= '0;
            r_s2_fit   <= 1'b0;
        end else if (w_s2_advance) begin
            // Empty slot presents zeros rather than stale data.
            r_s2_valid <= r_s1_valid;
            r_s2_imm   <= r_s1_valid ? w_pack_imm : '0;
            r_s2_fit   <= r_s1_valid && w_pack_fit;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_err_count <= '0;
        end else if (w_deliver && !r_s2_fit && (r_err_count != C_ERR_MAX)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign OutValid = r_s2_valid;
    assign Imm      = r_s2_imm;
    assign Fit      = r_s2_fit;
    assign ErrCount = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_field_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_field_encoder
//  Purpose  : Directed self-checking bench for imm_field_encoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_field_encoder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [63:0] BusImm;
    logic [1:0]  Ctrl;
    logic        OutValid;
    logic        OutReady;
    logic [25:0] Imm;
    logic        Fit;
    logic [7:0]  ErrCount;

    int checks = 0;
    int errors = 0;

    imm_field_encoder dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .BusImm   (BusImm),
        .Ctrl     (Ctrl),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Imm      (Imm),
        .Fit      (Fit),
        .ErrCount (ErrCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One request through an idle pipeline with OutReady held high.
    task automatic send(input string tag, input logic [63:0] bus, input logic [1:0] ctl,
                        input logic [25:0] exp_imm, input logic exp_fit,
                        input logic [7:0] exp_err);
        BusImm   = bus;
        Ctrl     = ctl;
        InValid  = 1'b1;
        OutReady = 1'b1;
        tick();                       // accept edge
        InValid = 1'b0;
        chk({tag, "_s1_only"}, OutValid, 1'b0);
        tick();                       // stage 2 loaded
        chk({tag, "_valid"}, OutValid, 1'b1);
        chk({tag, "_imm"},   Imm, exp_imm);
        chk({tag, "_fit"},   Fit, exp_fit);
        tick();                       // delivery edge
        chk({tag, "_err"},   ErrCount, exp_err);
    endtask

    initial begin
        Reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        BusImm   = '0;
        Ctrl     = 2'b00;
        tick();
        tick();
        chk("rst_inready", InReady, 1'b0);
        chk("rst_outvalid", OutValid, 1'b0);
        Reset = 1'b0;
        #1;
        chk("post_rst_inready", InReady, 1'b1);
        chk("post_rst_imm", Imm, 26'h0);
        chk("post_rst_fit", Fit, 1'b0);
        chk("post_rst_err", ErrCount, 8'd0);

        // Round-trip / boundary vectors.
        send("b_neg",    64'hFFFF_FFFF_FAAA_AAA8, 2'b10, 26'h2AA_AAAA, 1'b1, 8'd0);
        send("i_555",    64'h555,                 2'b00, 26'h15_5400,  1'b1, 8'd0);
        send("i_ovf",    64'h1000,                2'b00, 26'h0,        1'b0, 8'd1);
        send("d_minneg", 64'hFFFF_FFFF_FFFF_FF00, 2'b01, 26'h10_0000,  1'b1, 8'd1);
        send("d_ovf",    64'h100,                 2'b01, 26'h0,        1'b0, 8'd2);
        send("cbz_mis",  64'h6,                   2'b11, 26'h0,        1'b0, 8'd3);
        send("cbz_4",    64'h4,                   2'b11, 26'h20,       1'b1, 8'd3);
        send("b_ovf",    64'h0800_0000,           2'b10, 26'h0,        1'b0, 8'd4);

        // Backpressure: three requests with OutReady low.
        OutReady = 1'b0;
        InValid  = 1'b1;
        BusImm   = 64'h1;   Ctrl = 2'b00;     // I -> 0x400
        tick();
        BusImm   = 64'h8;   Ctrl = 2'b10;     // B -> 0x2
        tick();
        chk("bp_full_inready", InReady, 1'b0);
        chk("bp_head_valid", OutValid, 1'b1);
        chk("bp_head_imm", Imm, 26'h400);
        BusImm   = 64'h8;   Ctrl = 2'b11;     // CBZ -> 0x40
        tick();
        tick();
        chk("bp_hold_inready", InReady, 1'b0);
        chk("bp_hold_valid", OutValid, 1'b1);
        chk("bp_hold_imm", Imm, 26'h400);
        chk("bp_hold_fit", Fit, 1'b1);
        OutReady = 1'b1;
        #1;
        chk("bp_release_inready", InReady, 1'b1);
        tick();                               // deliver #1, accept #3
        InValid = 1'b0;
        chk("bp_second_imm", Imm, 26'h2);
        chk("bp_second_valid", OutValid, 1'b1);
        tick();                               // deliver #2
        chk("bp_third_imm", Imm, 26'h40);
        chk("bp_third_valid", OutValid, 1'b1);
        tick();                               // deliver #3
        chk("bp_drained", OutValid, 1'b0);
        chk("bp_err", ErrCount, 8'd4);

        // Saturation: 300 non-fitting results streamed at full rate.
        BusImm   = 64'h1000;
        Ctrl     = 2'b00;
        InValid  = 1'b1;
        OutReady = 1'b1;
        for (int i = 0; i < 302; i++) begin
            tick();
        end
        chk("sat_err", ErrCount, 8'd255);
        tick();
        chk("sat_hold", ErrCount, 8'd255);

        // Fill both stages, then reset.
        OutReady = 1'b0;
        tick();
        tick();
        chk("full_inready", InReady, 1'b0);
        chk("full_valid", OutValid, 1'b1);
        Reset = 1'b1;
        tick();
        chk("mid_rst_valid", OutValid, 1'b0);
        chk("mid_rst_err", ErrCount, 8'd0);
        chk("mid_rst_imm", Imm, 26'h0);
        chk("mid_rst_inready", InReady, 1'b0);
        Reset   = 1'b0;
        InValid = 1'b0;
        #1;
        chk("mid_rst_release_inready", InReady, 1'b1);
        tick();
        chk("mid_rst_discard", OutValid, 1'b0);

        send("b_minus4", 64'hFFFF_FFFF_FFFF_FFFC, 2'b10, 26'h3FF_FFFF, 1'b1, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
